// File: rtl/dino_pkg.sv
// Shared constants for the Dino game core.
// Holds debounce defaults and button polarity.
package dino_pkg;

    localparam int   DEBOUNCE_WIDTH = 8;
    localparam logic BTN_ACTIVE     = 1'b1;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/input_handler.sv
// Jump-button debouncer: shift-register history with hysteresis.
// Ports: clk, rst (sync, active-high), btn_jump (raw), jump_pressed (clean level).
module input_handler
    import dino_pkg::*;
#(
    parameter int WIDTH       = DEBOUNCE_WIDTH,
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_jump,
    output logic jump_pressed
);

    logic             btn_act;
    logic             s;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] counter_d;
    logic             jump_q;
    logic             jump_d;

    assign btn_act = (btn_jump == BTN_ACTIVE);

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            sync_ff #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (btn_act),
                .q   (s)
            );
        end else begin : g_nosync
            assign s = btn_act;
        end
    endgenerate

    // Output decision uses the history as it stands before this
    // edge's shift, giving the registered one-edge lag.
    always_comb begin
        counter_d = {counter[WIDTH-2:0], s};
        jump_d    = jump_q;
        if (&counter) begin
            jump_d = 1'b1;
        end else if (~|counter) begin
            jump_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            jump_q  <= 1'b0;
        end else begin
            counter <= counter_d;
            jump_q  <= jump_d;
        end
    end

    assign jump_pressed = jump_q;

endmodule

// File: tb/tb_input_handler.sv
// Self-checking bench for input_handler (WIDTH=8, SYNC_STAGES=0).
// Scoreboard of expected history/output, popped after each edge.
module tb_input_handler;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] cnt;
        logic         jp;
    } exp_t;

    logic clk;
    logic rst;
    logic btn_jump;
    logic jump_pressed;

    int total;
    int bad;

    exp_t sb[$];

    // Reference model: run-length counters rather than a shift register.
    logic [W-1:0] m_hist;
    logic         m_jp;
    int           m_ones;
    int           m_zeros;

    input_handler #(
        .WIDTH       (W),
        .SYNC_STAGES (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_jump     (btn_jump),
        .jump_pressed (jump_pressed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic b);
        exp_t e;
        rst      = r;
        btn_jump = b;
        if (r) begin
            m_hist  = '0;
            m_jp    = 1'b0;
            m_ones  = 0;
            m_zeros = W;
        end else begin
            if (m_ones >= W) m_jp = 1'b1;
            else if (m_zeros >= W) m_jp = 1'b0;
            m_hist = {m_hist[W-2:0], b};
            if (b) begin
                m_ones  = (m_ones < W) ? m_ones + 1 : W;
                m_zeros = 0;
            end else begin
                m_zeros = (m_zeros < W) ? m_zeros + 1 : W;
                m_ones  = 0;
            end
        end
        e.cnt = m_hist;
        e.jp  = m_jp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("cnt", 32'(dut.counter), 32'(e.cnt));
        chk("jp", 32'(jump_pressed), 32'(e.jp));
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(1'b0, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] exp_c;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        btn_jump = 1'b0;
        m_hist   = '0;
        m_jp     = 1'b0;
        m_ones   = 0;
        m_zeros  = W;

        // Reset
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_cnt", 32'(dut.counter), 32'h0);
        chk("rst_jp", 32'(jump_pressed), 32'h0);

        // Press: counter fills 01,03,...,FF; output one edge later
        exp_c = '0;
        for (int i = 1; i <= W; i++) begin
            step(1'b0, 1'b1);
            exp_c = {exp_c[W-2:0], 1'b1};
            chk("press_cnt", 32'(dut.counter), 32'(exp_c));
            chk("press_jp_lo", 32'(jump_pressed), 32'h0);
        end
        step(1'b0, 1'b1);
        chk("press_jp_hi", 32'(jump_pressed), 32'h1);

        // Release: FE,FC,...,00; output drops one edge later
        exp_c = '1;
        for (int i = 1; i <= W; i++) begin
            step(1'b0, 1'b0);
            exp_c = {exp_c[W-2:0], 1'b0};
            chk("rel_cnt", 32'(dut.counter), 32'(exp_c));
            chk("rel_jp_hi", 32'(jump_pressed), 32'h1);
        end
        step(1'b0, 1'b0);
        chk("rel_jp_lo", 32'(jump_pressed), 32'h0);

        // Bounce 1-0-1 at 3-cycle intervals, then steady press
        hold(1'b1, 3);
        hold(1'b0, 3);
        hold(1'b1, 3);
        hold(1'b0, 3);
        chk("bounce_jp", 32'(jump_pressed), 32'h0);
        hold(1'b1, W);
        chk("bounce_pre", 32'(jump_pressed), 32'h0);
        step(1'b0, 1'b1);
        chk("bounce_post", 32'(jump_pressed), 32'h1);

        // Single-cycle 0 glitch while pressed
        hold(1'b1, 2);
        step(1'b0, 1'b0);
        chk("glitch_cnt", 32'(dut.counter), 32'hFE);
        hold(1'b1, W + 2);
        chk("glitch_jp", 32'(jump_pressed), 32'h1);

        // Almost-full press then 0 must not assert
        hold(1'b0, W + 2);
        hold(1'b1, W - 1);
        step(1'b0, 1'b0);
        hold(1'b0, 2);
        chk("short_press", 32'(jump_pressed), 32'h0);

        // Single-cycle 1 glitch while released
        hold(1'b0, W);
        step(1'b0, 1'b1);
        chk("mirror_cnt", 32'(dut.counter), 32'h01);
        hold(1'b0, W + 2);
        chk("mirror_jp", 32'(jump_pressed), 32'h0);

        // Reset mid-press
        hold(1'b1, W + 3);
        chk("mid_pre", 32'(jump_pressed), 32'h1);
        step(1'b1, 1'b1);
        chk("mid_cnt", 32'(dut.counter), 32'h0);
        chk("mid_jp", 32'(jump_pressed), 32'h0);
        hold(1'b1, W);
        chk("mid_8", 32'(jump_pressed), 32'h0);
        step(1'b0, 1'b1);
        chk("mid_9", 32'(jump_pressed), 32'h1);

        // Random runs of varying length
        for (int i = 0; i < 60; i++) begin
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
